// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// Holds op encodings, the FSM state type and the iteration count.
// Imported by muldiv_unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  // One shift-add / shift-subtract step per operand bit.
  localparam int MD_ITERS = MD_WIDTH;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Purpose: MIPS MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// Latency: start -> done is WIDTH+1 cycles for every op, including divide by zero.
// Backpressure: none; start is ignored while busy, MTHI/MTLO ignored while busy.
// Ports: clk, rst_n (async active-low); start/op/A/B request (sampled in IDLE);
//        hi_we/lo_we/wdata MTHI/MTLO writes; busy, done (1-cycle pulse), hi, lo
//        all registered.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_ITERS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e          state_q, state_d;
  logic [2*WIDTH-1:0] acc_q;     // {partial hi/remainder, multiplier/quotient bits}
  logic [WIDTH-1:0]   opd_q;     // multiplicand or divisor magnitude
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic               neg_q_q;   // negate product (mult) or quotient (div)
  logic               neg_r_q;   // negate remainder (DIV with negative dividend)
  logic               dbz_q;     // divide by zero
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Operand conditioning at start
  logic             op_signed, op_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = op_signed & A[WIDTH-1];
    b_neg     = op_signed & B[WIDTH-1];
    a_mag     = a_neg ? (WIDTH'(0) - A) : A;
    b_mag     = b_neg ? (WIDTH'(0) - B) : B;
  end

  // Shared (WIDTH+1)-bit adder/subtractor. The extra top bit of the sum is the
  // carry-out, which for a subtract means "no borrow" (trial remainder >= divisor).
  logic [WIDTH:0]     add_a, add_b;
  logic [WIDTH+1:0]   sum;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (is_div_q) begin
      add_a = acc_q[2*WIDTH-1:WIDTH-1];           // remainder shifted left by one
      add_b = {1'b0, opd_q};
    end else begin
      add_a = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b = acc_q[0] ? {1'b0, opd_q} : '0;
    end
    sum = {1'b0, add_a} + {1'b0, (is_div_q ? ~add_b : add_b)} + (WIDTH+2)'(is_div_q);

    if (is_div_q) begin
      if (sum[WIDTH+1])
        acc_next = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        acc_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction for commit
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, hi_commit, lo_commit;

  always_comb begin
    prod_fix = neg_q_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
    quo_fix  = neg_q_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      // With a zero divisor every trial subtract succeeds, so the remainder
      // is |A|; re-applying the dividend sign restores A exactly. Only the
      // quotient needs forcing to all ones.
      hi_commit = rem_fix;
      lo_commit = dbz_q ? '1 : quo_fix;
    end else begin
      hi_commit = prod_fix[2*WIDTH-1:WIDTH];
      lo_commit = prod_fix[WIDTH-1:0];
    end
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CW'(1)) state_d = FIX;  // counter hits 0 on this edge
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opd_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= CW'(WIDTH);
            is_div_q <= op_div;
            dbz_q    <= op_div && (B == '0);
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= op_div & a_neg;
            opd_q    <= op_div ? b_mag : a_mag;
            acc_q    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
          end
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          hi_q   <= hi_commit;
          lo_q   <= lo_commit;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: busy_q <= 1'b0;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
